// File: rtl/jtag_csr_dr.sv
// JTAG data-register bank (BYPASS/IDCODE/CSR_ADDR/CSR_DATA/CSR_STAT) driving a single-outstanding CSR master.
// Optional macro JTAG_CSR_AUTOINC_EN: post-increment csr_addr on every completed access.
module jtag_csr_dr #(
  parameter int                IR_LEN      = 5,
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [31:0]       IDCODE_VAL  = 32'h1000_0001,
  parameter logic [IR_LEN-1:0] IDCODE_OP   = 5'h01,
  parameter logic [IR_LEN-1:0] CSR_ADDR_OP = 5'h08,
  parameter logic [IR_LEN-1:0] CSR_DATA_OP = 5'h09,
  parameter logic [IR_LEN-1:0] CSR_STAT_OP = 5'h0A
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  input  logic              capdr,
  input  logic              shiftdr,
  input  logic              updatedr,
  input  logic [IR_LEN-1:0] curr_inst,
  output logic              tdo,
  output logic              csr_req,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic              csr_ack,
  input  logic [DATA_W-1:0] csr_rdata
);

  typedef enum logic [2:0] {SEL_BYPASS, SEL_IDCODE, SEL_ADDR, SEL_DATA, SEL_STAT} sel_t;
  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  sel_t              w_sel;
  state_t            r_state, w_state_next;
  logic              r_bypass;
  logic [31:0]       r_idcode;
  logic [ADDR_W:0]   r_addr_dr;
  logic [DATA_W-1:0] r_data_dr;
  logic [2:0]        r_stat_dr;
  logic              r_tdo;
  logic              w_dr_lsb;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic [DATA_W-1:0] r_rd_buf, w_rd_buf_next;
  logic              r_rd_valid, w_rd_valid_next;
  logic              r_overrun, w_overrun_next;
  logic              w_ack, w_upd_addr, w_upd_data, w_upd_stat, w_cap_data;

  always_comb begin
    w_sel = SEL_BYPASS;
    if (curr_inst == IDCODE_OP)        w_sel = SEL_IDCODE;
    else if (curr_inst == CSR_ADDR_OP) w_sel = SEL_ADDR;
    else if (curr_inst == CSR_DATA_OP) w_sel = SEL_DATA;
    else if (curr_inst == CSR_STAT_OP) w_sel = SEL_STAT;
  end

  assign w_upd_addr = updatedr && (w_sel == SEL_ADDR);
  assign w_upd_data = updatedr && (w_sel == SEL_DATA);
  assign w_upd_stat = updatedr && (w_sel == SEL_STAT);
  assign w_cap_data = capdr && (w_sel == SEL_DATA);
  assign w_ack      = csr_ack && (r_state == ST_PEND);

  // Only the selected DR captures or shifts; the rest hold their contents.
  always_ff @(posedge tck) begin
    if (rst) begin
      r_bypass  <= 1'b0;
      r_idcode  <= IDCODE_VAL;
      r_addr_dr <= '0;
      r_data_dr <= '0;
      r_stat_dr <= '0;
    end else if (capdr) begin
      case (w_sel)
        SEL_IDCODE: r_idcode  <= IDCODE_VAL;
        SEL_ADDR:   r_addr_dr <= {~r_we, r_addr};
        SEL_DATA:   r_data_dr <= r_rd_buf;
        SEL_STAT:   r_stat_dr <= {r_rd_valid, r_overrun, (r_state == ST_PEND)};
        default:    r_bypass  <= 1'b0;
      endcase
    end else if (shiftdr) begin
      case (w_sel)
        SEL_IDCODE: r_idcode  <= {tdi, r_idcode[31:1]};
        SEL_ADDR:   r_addr_dr <= {tdi, r_addr_dr[ADDR_W:1]};
        SEL_DATA:   r_data_dr <= {tdi, r_data_dr[DATA_W-1:1]};
        SEL_STAT:   r_stat_dr <= {tdi, r_stat_dr[2:1]};
        default:    r_bypass  <= tdi;
      endcase
    end
  end

  always_comb begin
    case (w_sel)
      SEL_IDCODE: w_dr_lsb = r_idcode[0];
      SEL_ADDR:   w_dr_lsb = r_addr_dr[0];
      SEL_DATA:   w_dr_lsb = r_data_dr[0];
      SEL_STAT:   w_dr_lsb = r_stat_dr[0];
      default:    w_dr_lsb = r_bypass;
    endcase
  end

  always_ff @(negedge tck) begin
    if (rst)          r_tdo <= 1'b0;
    else if (shiftdr) r_tdo <= w_dr_lsb;
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_buf   <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_rd_buf   <= w_rd_buf_next;
      r_rd_valid <= w_rd_valid_next;
      r_overrun  <= w_overrun_next;
    end
  end

  // Clears are applied before sets so a coincident set always wins.
  always_comb begin
    w_state_next    = r_state;
    w_we_next       = r_we;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_rd_buf_next   = r_rd_buf;
    w_rd_valid_next = r_rd_valid;
    w_overrun_next  = r_overrun;
    if (w_cap_data)                  w_rd_valid_next = 1'b0;
    if (w_upd_stat && r_stat_dr[1])  w_overrun_next  = 1'b0;
    if (w_ack) begin
      w_state_next = ST_IDLE;
      if (!r_we) begin
        w_rd_buf_next   = csr_rdata;
        w_rd_valid_next = 1'b1;
      end
`ifdef JTAG_CSR_AUTOINC_EN
      w_addr_next = r_addr + ADDR_W'(1);
`endif
    end
    if ((r_state == ST_IDLE) || w_ack) begin
      if (w_upd_addr) begin
        w_addr_next = r_addr_dr[ADDR_W-1:0];
        if (r_addr_dr[ADDR_W]) begin
          w_we_next    = 1'b0;
          w_state_next = ST_PEND;
        end
      end else if (w_upd_data) begin
        w_wdata_next = r_data_dr;
        w_we_next    = 1'b1;
        w_state_next = ST_PEND;
      end
    end else if (w_upd_addr || w_upd_data) begin
      w_overrun_next = 1'b1;
    end
  end

  assign tdo       = r_tdo;
  assign csr_req   = (r_state == ST_PEND);
  assign csr_we    = r_we;
  assign csr_addr  = r_addr;
  assign csr_wdata = r_wdata;

endmodule

// File: tb/tb_jtag_csr_dr.sv
// Scoreboard bench for jtag_csr_dr: expectations are queued as stimulus is issued and compared as results appear.
// Honours JTAG_CSR_AUTOINC_EN for the address-increment expectations.
module tb_jtag_csr_dr;
  localparam int IR_LEN = 5;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef JTAG_CSR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam logic [IR_LEN-1:0] OP_IDCODE = 5'h01;
  localparam logic [IR_LEN-1:0] OP_ADDR   = 5'h08;
  localparam logic [IR_LEN-1:0] OP_DATA   = 5'h09;
  localparam logic [IR_LEN-1:0] OP_STAT   = 5'h0A;
  localparam logic [IR_LEN-1:0] OP_UNK    = 5'h1F;

  logic              tck = 1'b0;
  logic              rst, tdi, capdr, shiftdr, updatedr, csr_ack;
  logic [IR_LEN-1:0] curr_inst;
  logic              tdo, csr_req, csr_we;
  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_wdata, csr_rdata;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  jtag_csr_dr dut (
    .tck(tck), .rst(rst), .tdi(tdi), .capdr(capdr), .shiftdr(shiftdr), .updatedr(updatedr),
    .curr_inst(curr_inst), .tdo(tdo), .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_ack(csr_ack), .csr_rdata(csr_rdata)
  );

  always #5 tck = ~tck;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s val=%h", tag, got);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", got, 64'hx);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  function automatic logic [63:0] req_word(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
    return {22'd0, req, we, a, d};
  endfunction

  function automatic logic [63:0] dut_req_word();
    return req_word(csr_req, csr_we, csr_addr, csr_wdata);
  endfunction

  function automatic logic [ADDR_W-1:0] after_ack(input logic [ADDR_W-1:0] a);
    return AUTOINC ? a + ADDR_W'(1) : a;
  endfunction

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // Capture, shift n bits LSB-first, optionally update (optionally with a coincident ack).
  task automatic scan_dr(input logic [IR_LEN-1:0] inst, input int n, input logic [63:0] din,
                         input bit do_upd, input bit ack_on_upd, output logic [63:0] dout);
    dout = '0;
    curr_inst = inst;
    capdr = 1'b1;
    tick();
    capdr = 1'b0;
    shiftdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      tick();
      dout[i] = tdo;
    end
    shiftdr = 1'b0;
    tdi = 1'b0;
    if (do_upd) begin
      updatedr = 1'b1;
      csr_ack = ack_on_upd;
      tick();
      updatedr = 1'b0;
      csr_ack = 1'b0;
    end
  endtask

  task automatic ack_pulse(input logic [DATA_W-1:0] rd);
    csr_ack = 1'b1;
    csr_rdata = rd;
    tick();
    csr_ack = 1'b0;
    csr_rdata = '0;
  endtask

  logic [63:0] dout;
  logic [ADDR_W-1:0] a;

  initial begin
    rst = 1'b1; tdi = 1'b0; capdr = 1'b0; shiftdr = 1'b0; updatedr = 1'b0;
    csr_ack = 1'b0; csr_rdata = '0; curr_inst = OP_IDCODE;
    repeat (3) tick();
    sb_push("reset_outs", 64'd0);
    sb_pop({tdo, dut_req_word()});
    rst = 1'b0;
    tick();

    sb_push("idcode", 64'h1000_0001);
    scan_dr(OP_IDCODE, 32, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);

    sb_push("bypass", 64'hA);
    scan_dr(OP_UNK, 4, 64'h5, 1'b0, 1'b0, dout);
    sb_pop(dout);

    // write: address only, then data launches the request
    sb_push("addr_wr_noreq", req_word(1'b0, 1'b0, 8'h12, 32'h0));
    scan_dr(OP_ADDR, 9, 64'h012, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("wr_req", req_word(1'b1, 1'b1, 8'h12, 32'hDEADBEEF));
    scan_dr(OP_DATA, 32, 64'hDEADBEEF, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    repeat (3) tick();
    sb_push("wr_hold", req_word(1'b1, 1'b1, 8'h12, 32'hDEADBEEF));
    sb_pop(dut_req_word());
    ack_pulse(32'h0);
    sb_push("wr_done", req_word(1'b0, 1'b1, after_ack(8'h12), 32'hDEADBEEF));
    sb_pop(dut_req_word());

    // read
    sb_push("rd_req", req_word(1'b1, 1'b0, 8'h34, 32'hDEADBEEF));
    scan_dr(OP_ADDR, 9, 64'h134, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    ack_pulse(32'hCAFEF00D);
    sb_push("rd_done", req_word(1'b0, 1'b0, after_ack(8'h34), 32'hDEADBEEF));
    sb_pop(dut_req_word());
    sb_push("stat_rdvalid", 64'h4);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);
    sb_push("rd_data", 64'hCAFEF00D);
    scan_dr(OP_DATA, 32, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);
    sb_push("stat_cleared", 64'h0);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);

    // overrun
    sb_push("addr40", req_word(1'b0, 1'b0, 8'h40, 32'hDEADBEEF));
    scan_dr(OP_ADDR, 9, 64'h040, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("wr1_req", req_word(1'b1, 1'b1, 8'h40, 32'h11111111));
    scan_dr(OP_DATA, 32, 64'h11111111, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("ovr_fields", req_word(1'b1, 1'b1, 8'h40, 32'h11111111));
    scan_dr(OP_DATA, 32, 64'h22222222, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("stat_ovr", 64'h3);
    scan_dr(OP_STAT, 3, 64'h2, 1'b1, 1'b0, dout);
    sb_pop(dout);
    sb_push("stat_w1c", 64'h1);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);
    ack_pulse(32'h0);
    a = after_ack(8'h40);
    sb_push("wr1_done", req_word(1'b0, 1'b1, a, 32'h11111111));
    sb_pop(dut_req_word());

    // ack coincident with a new DATA update
    sb_push("wr3_req", req_word(1'b1, 1'b1, a, 32'h33333333));
    scan_dr(OP_DATA, 32, 64'h33333333, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("b2b_req", req_word(1'b1, 1'b1, after_ack(a), 32'h44444444));
    scan_dr(OP_DATA, 32, 64'h44444444, 1'b1, 1'b1, dout);
    sb_pop(dut_req_word());
    sb_push("stat_b2b", 64'h1);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);

    // reset while pending
    rst = 1'b1;
    tick();
    sb_push("rst_pend", 64'd0);
    sb_pop({tdo, dut_req_word()});
    rst = 1'b0;
    tick();
    sb_push("stat_after_rst", 64'h0);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);

    // address wrap under auto-increment
    sb_push("addrff", req_word(1'b0, 1'b0, 8'hFF, 32'h0));
    scan_dr(OP_ADDR, 9, 64'h0FF, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    sb_push("burst1", req_word(1'b1, 1'b1, 8'hFF, 32'hAAAA0001));
    scan_dr(OP_DATA, 32, 64'hAAAA0001, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    ack_pulse(32'h0);
    sb_push("burst2", req_word(1'b1, 1'b1, after_ack(8'hFF), 32'hAAAA0002));
    scan_dr(OP_DATA, 32, 64'hAAAA0002, 1'b1, 1'b0, dout);
    sb_pop(dut_req_word());
    ack_pulse(32'h0);
    sb_push("burst_done", req_word(1'b0, 1'b1, after_ack(after_ack(8'hFF)), 32'hAAAA0002));
    sb_pop(dut_req_word());

    // ack while idle is ignored
    ack_pulse(32'h5555AAAA);
    sb_push("idle_ack", req_word(1'b0, 1'b1, after_ack(after_ack(8'hFF)), 32'hAAAA0002));
    sb_pop(dut_req_word());
    sb_push("stat_idle_ack", 64'h0);
    scan_dr(OP_STAT, 3, 64'h0, 1'b0, 1'b0, dout);
    sb_pop(dout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
